// File: rtl/tcp_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing the eth_vlg raw-TCP transmit port between N byte streams.
// Optional header byte per grant when TCP_TX_ARB_HDR_EN is defined.
module tcp_tx_arbiter #(
  parameter int N          = 4,
  parameter int MAX_MSG    = 1024,
  parameter int IDLE_TICKS = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 connected,
  input  logic [N-1:0]         req_vin,
  input  logic [N*8-1:0]       req_din,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_cts,
  input  logic                 tcp_cts,
  output logic [7:0]           tcp_din,
  output logic                 tcp_vin,
  output logic                 tcp_snd,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy
);

  localparam int GW = $clog2(N);
  localparam int BW = $clog2(MAX_MSG + 1);
  localparam int IW = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS) : 1;

  localparam logic [BW-1:0] BYTE_LAST = BW'(MAX_MSG - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);
  localparam logic [GW-1:0] GNT_MAX   = GW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          vin_q, vin_d;
  logic [7:0]    din_q, din_d;

  logic          cts_ok;
  logic          xfer;
  logic          xfer_last;
  logic [7:0]    xfer_byte;
  logic          sel_found;
  logic [GW-1:0] sel_idx;

  assign cts_ok    = tcp_cts && connected;
  assign xfer      = (state_q == STREAM) && cts_ok && req_vin[gnt_q];
  assign xfer_last = req_last[gnt_q];
  assign xfer_byte = req_din[{gnt_q, 3'b000} +: 8];

  // Only the granted requester ever sees ready, and only while the stack can take a byte.
  always_comb begin
    req_cts = '0;
    for (int i = 0; i < N; i++) begin
      req_cts[i] = (state_q == STREAM) && (gnt_q == GW'(i)) && cts_ok;
    end
  end

  // First active request at or after the round-robin pointer, wrapping modulo N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!sel_found && req_vin[(int'(rr_q) + k) % N]) begin
        sel_found = 1'b1;
        sel_idx   = GW'((int'(rr_q) + k) % N);
      end
    end
  end

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    vin_d      = 1'b0;
    din_d      = 8'h00;

    if (xfer) begin
      vin_d = 1'b1;
      din_d = xfer_byte;
    end

    unique case (state_q)
      IDLE: begin
        if (connected && sel_found) begin
          gnt_d      = sel_idx;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
`ifdef TCP_TX_ARB_HDR_EN
          state_d    = HDR;
`else
          state_d    = STREAM;
`endif
        end
      end

`ifdef TCP_TX_ARB_HDR_EN
      HDR: begin
        if (cts_ok) begin
          vin_d      = 1'b1;
          din_d      = {4'hA, 1'b0, 3'(gnt_q)};
          byte_cnt_d = byte_cnt_q + 1'b1;
          idle_cnt_d = '0;
          state_d    = (byte_cnt_q == BYTE_LAST) ? FLUSH : STREAM;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = FLUSH;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
`else
      HDR: state_d = IDLE;
`endif

      STREAM: begin
        // A transfer always beats the idle timeout in the same cycle.
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          idle_cnt_d = '0;
          if (xfer_last || (byte_cnt_q == BYTE_LAST)) begin
            state_d = FLUSH;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = FLUSH;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      FLUSH: begin
        rr_d    = (gnt_q == GNT_MAX) ? '0 : gnt_q + GW'(1);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Losing the connection abandons the grant without flushing or advancing fairness.
    if (!connected) begin
      state_d = IDLE;
      rr_d    = rr_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      vin_q      <= 1'b0;
      din_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      vin_q      <= vin_d;
      din_q      <= din_d;
    end
  end

  // The final byte registered on entry to FLUSH is on tcp_vin in the same cycle as the strobe.
  assign tcp_snd = (state_q == FLUSH) && connected && (byte_cnt_q != '0);
  assign tcp_vin = vin_q;
  assign tcp_din = din_q;
  assign gnt_id  = gnt_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed testbench for tcp_tx_arbiter (default build, N=4, MAX_MSG=8, IDLE_TICKS=16).
module tb_tcp_tx_arbiter;

  localparam int N          = 4;
  localparam int MAX_MSG    = 8;
  localparam int IDLE_TICKS = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           connected;
  logic [N-1:0]   req_vin;
  logic [N*8-1:0] req_din;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_cts;
  logic           tcp_cts;
  logic [7:0]     tcp_din;
  logic           tcp_vin;
  logic           tcp_snd;
  logic [1:0]     gnt_id;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Per-requester byte queues: {last, byte}
  logic [8:0] qmem [N][32];
  int         qhead [N];
  int         qtail [N];

  // Output log: {snd, vin, din} for every cycle with vin or snd, plus the cycle index
  logic [9:0] log_q [$];
  int         log_t [$];

  tcp_tx_arbiter #(
    .N(N), .MAX_MSG(MAX_MSG), .IDLE_TICKS(IDLE_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .connected(connected),
    .req_vin(req_vin), .req_din(req_din), .req_last(req_last), .req_cts(req_cts),
    .tcp_cts(tcp_cts), .tcp_din(tcp_din), .tcp_vin(tcp_vin), .tcp_snd(tcp_snd),
    .gnt_id(gnt_id), .busy(busy)
  );

  always #4 clk = ~clk;

  task automatic q_clear();
    for (int i = 0; i < N; i++) begin
      qhead[i] = 0;
      qtail[i] = 0;
    end
  endtask

  task automatic q_push(input int r, input logic [7:0] b, input logic l);
    qmem[r][qtail[r]] = {l, b};
    qtail[r]++;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (qhead[i] < qtail[i]) begin
        req_vin[i]         = 1'b1;
        req_din[i*8 +: 8]  = qmem[i][qhead[i]][7:0];
        req_last[i]        = qmem[i][qhead[i]][8];
      end else begin
        req_vin[i]         = 1'b0;
        req_din[i*8 +: 8]  = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: note handshakes before the edge, log outputs after it, re-drive requesters.
  task automatic step();
    logic [N-1:0] mv;
    mv = req_vin & req_cts;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (mv[i]) qhead[i]++;
    if (tcp_vin || tcp_snd) begin
      log_q.push_back({tcp_snd, tcp_vin, tcp_din});
      log_t.push_back(cyc);
    end
    drive_reqs();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q_clear();
    drive_reqs();
    step();
    step();
    rst = 1'b0;
    log_q.delete();
    log_t.delete();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q_clear();
    q_push(1, 8'hEE, 1'b1);
    drive_reqs();
    step();
    step();
    checks++; if (tcp_vin !== 1'b0) begin failures++; $display("FAIL reset_vin got=%b exp=0", tcp_vin); end
    checks++; if (tcp_din !== 8'h00) begin failures++; $display("FAIL reset_din got=%h exp=00", tcp_din); end
    checks++; if (tcp_snd !== 1'b0) begin failures++; $display("FAIL reset_snd got=%b exp=0", tcp_snd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_gnt got=%0d exp=0", gnt_id); end
    checks++; if (req_cts !== 4'b0000) begin failures++; $display("FAIL reset_cts got=%b exp=0000", req_cts); end
    rst = 1'b0;
    q_clear();
    drive_reqs();
    #1;
  endtask

  task automatic test_single_msg();
    do_reset();
    q_push(2, 8'h11, 1'b0);
    q_push(2, 8'h22, 1'b0);
    q_push(2, 8'h33, 1'b1);
    drive_reqs();
    #1;
    checks++; if (req_cts !== 4'b0000) begin failures++; $display("FAIL single_idle_cts got=%b exp=0000", req_cts); end
    step();
    checks++; if (busy !== 1'b1 || gnt_id !== 2'd2) begin failures++; $display("FAIL single_grant busy=%b gnt=%0d exp busy=1 gnt=2", busy, gnt_id); end
    checks++; if (req_cts !== 4'b0100 || tcp_vin !== 1'b0) begin failures++; $display("FAIL single_cts cts=%b vin=%b exp cts=0100 vin=0", req_cts, tcp_vin); end
    step();
    checks++; if ({tcp_vin, tcp_din, tcp_snd} !== {1'b1, 8'h11, 1'b0}) begin failures++; $display("FAIL single_b0 vin=%b din=%h snd=%b exp 1/11/0", tcp_vin, tcp_din, tcp_snd); end
    step();
    checks++; if ({tcp_vin, tcp_din, tcp_snd} !== {1'b1, 8'h22, 1'b0}) begin failures++; $display("FAIL single_b1 vin=%b din=%h snd=%b exp 1/22/0", tcp_vin, tcp_din, tcp_snd); end
    step();
    checks++; if ({tcp_vin, tcp_din, tcp_snd} !== {1'b1, 8'h33, 1'b1}) begin failures++; $display("FAIL single_b2 vin=%b din=%h snd=%b exp 1/33/1", tcp_vin, tcp_din, tcp_snd); end
    step();
    checks++; if ({tcp_vin, tcp_snd, busy} !== 3'b000) begin failures++; $display("FAIL single_end vin=%b snd=%b busy=%b exp 0/0/0", tcp_vin, tcp_snd, busy); end
  endtask

  task automatic test_round_robin();
    logic [9:0] exp_q [$];
    int gap;
    do_reset();
    q_push(0, 8'hA0, 1'b0);
    q_push(0, 8'hA1, 1'b1);
    q_push(3, 8'hB0, 1'b0);
    q_push(3, 8'hB1, 1'b1);
    drive_reqs();
    #1;
    repeat (12) step();
    exp_q = '{10'h1A0, 10'h3A1, 10'h1B0, 10'h3B1};
    checks++; if (log_q.size() !== exp_q.size()) begin failures++; $display("FAIL rr_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k][9:8] !== exp_q[k][9:8] || (exp_q[k][8] && log_q[k][7:0] !== exp_q[k][7:0])) begin
        failures++; $display("FAIL rr_seq[%0d] got=%h exp=%h", k, log_q[k], exp_q[k]);
      end
    end
    gap = (log_t.size() >= 3) ? (log_t[2] - log_t[1]) : -1;
    checks++; if (gap !== 3) begin failures++; $display("FAIL rr_gap got=%0d exp=3", gap); end

    log_q.delete();
    log_t.delete();
    q_push(1, 8'hC1, 1'b1);
    q_push(0, 8'hD0, 1'b1);
    drive_reqs();
    #1;
    repeat (10) step();
    exp_q = '{10'h3D0, 10'h3C1};
    checks++; if (log_q.size() !== exp_q.size()) begin failures++; $display("FAIL rr2_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== exp_q[k]) begin failures++; $display("FAIL rr2_seq[%0d] got=%h exp=%h", k, log_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp_q [$];
    int nlog;
    do_reset();
    for (int b = 0; b < 6; b++) q_push(1, 8'h40 + 8'(b), (b == 5));
    drive_reqs();
    #1;
    repeat (3) step();
    tcp_cts = 1'b0;
    #1;
    checks++; if (req_cts !== 4'b0000) begin failures++; $display("FAIL bp_cts_fall got=%b exp=0000", req_cts); end
    checks++; if (tcp_vin !== 1'b1 || tcp_din !== 8'h41) begin failures++; $display("FAIL bp_inflight vin=%b din=%h exp 1/41", tcp_vin, tcp_din); end
    nlog = log_q.size();
    repeat (5) step();
    checks++; if (log_q.size() !== nlog) begin failures++; $display("FAIL bp_stall_out got=%0d extra entries exp=0", log_q.size() - nlog); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b exp=1", busy); end
    tcp_cts = 1'b1;
    #1;
    repeat (12) step();
    exp_q = '{10'h140, 10'h141, 10'h142, 10'h143, 10'h144, 10'h345};
    checks++; if (log_q.size() !== exp_q.size()) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== exp_q[k]) begin failures++; $display("FAIL bp_seq[%0d] got=%h exp=%h", k, log_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_idle_timeout();
    logic early_snd;
    do_reset();
    q_push(1, 8'h50, 1'b0);
    q_push(1, 8'h51, 1'b0);
    drive_reqs();
    #1;
    repeat (3) step();
    checks++; if (tcp_vin !== 1'b1 || tcp_din !== 8'h51) begin failures++; $display("FAIL idle_b1 vin=%b din=%h exp 1/51", tcp_vin, tcp_din); end
    early_snd = 1'b0;
    repeat (15) begin
      step();
      if (tcp_snd !== 1'b0 || busy !== 1'b1) early_snd = 1'b1;
    end
    checks++; if (early_snd !== 1'b0) begin failures++; $display("FAIL idle_early got=%b exp=0", early_snd); end
    step();
    checks++; if (tcp_snd !== 1'b1 || tcp_vin !== 1'b0) begin failures++; $display("FAIL idle_flush snd=%b vin=%b exp 1/0", tcp_snd, tcp_vin); end
    step();
    checks++; if (busy !== 1'b0 || tcp_snd !== 1'b0) begin failures++; $display("FAIL idle_release busy=%b snd=%b exp 0/0", busy, tcp_snd); end
  endtask

  task automatic test_max_msg();
    logic [9:0] exp_q [$];
    do_reset();
    for (int b = 0; b < 20; b++) q_push(0, 8'(b), (b == 19));
    q_push(1, 8'h80, 1'b0);
    q_push(1, 8'h81, 1'b1);
    drive_reqs();
    #1;
    repeat (45) step();
    for (int b = 0; b < 8; b++) exp_q.push_back((b == 7) ? (10'h300 | 10'(b)) : (10'h100 | 10'(b)));
    exp_q.push_back(10'h180);
    exp_q.push_back(10'h381);
    for (int b = 8; b < 16; b++) exp_q.push_back((b == 15) ? (10'h300 | 10'(b)) : (10'h100 | 10'(b)));
    for (int b = 16; b < 20; b++) exp_q.push_back((b == 19) ? (10'h300 | 10'(b)) : (10'h100 | 10'(b)));
    checks++; if (log_q.size() !== exp_q.size()) begin failures++; $display("FAIL cap_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== exp_q[k]) begin failures++; $display("FAIL cap_seq[%0d] got=%h exp=%h", k, log_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_disconnect_and_reset();
    logic [9:0] exp_q [$];
    do_reset();
    for (int b = 0; b < 10; b++) q_push(2, 8'h60 + 8'(b), (b == 9));
    drive_reqs();
    #1;
    repeat (5) step();
    connected = 1'b0;
    #1;
    checks++; if (req_cts !== 4'b0000) begin failures++; $display("FAIL dis_cts got=%b exp=0000", req_cts); end
    step();
    checks++; if ({busy, tcp_vin, tcp_snd} !== 3'b000) begin failures++; $display("FAIL dis_idle busy=%b vin=%b snd=%b exp 0/0/0", busy, tcp_vin, tcp_snd); end
    connected = 1'b1;
    q_push(3, 8'h77, 1'b1);
    drive_reqs();
    #1;
    repeat (20) step();
    for (int b = 0; b < 10; b++) exp_q.push_back((b == 9) ? (10'h300 | 10'(8'h60 + b)) : (10'h100 | 10'(8'h60 + b)));
    exp_q.push_back(10'h377);
    checks++; if (log_q.size() !== exp_q.size()) begin failures++; $display("FAIL dis_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== exp_q[k]) begin failures++; $display("FAIL dis_seq[%0d] got=%h exp=%h", k, log_q[k], exp_q[k]); end
    end

    q_clear();
    for (int b = 0; b < 5; b++) q_push(1, 8'h90 + 8'(b), (b == 4));
    drive_reqs();
    #1;
    repeat (3) step();
    checks++; if (busy !== 1'b1 || tcp_vin !== 1'b1) begin failures++; $display("FAIL rst_pre busy=%b vin=%b exp 1/1", busy, tcp_vin); end
    rst = 1'b1;
    step();
    checks++; if ({tcp_vin, tcp_din, tcp_snd, busy} !== 11'b0) begin failures++; $display("FAIL rst_mid vin=%b din=%h snd=%b busy=%b exp all 0", tcp_vin, tcp_din, tcp_snd, busy); end
    checks++; if (gnt_id !== 2'd0 || req_cts !== 4'b0000) begin failures++; $display("FAIL rst_mid_gnt gnt=%0d cts=%b exp 0/0000", gnt_id, req_cts); end
    rst = 1'b0;
    q_clear();
    drive_reqs();
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    connected = 1'b1;
    tcp_cts   = 1'b1;
    req_vin   = '0;
    req_din   = '0;
    req_last  = '0;
    q_clear();
    test_reset();
    test_single_msg();
    test_round_robin();
    test_backpressure();
    test_idle_timeout();
    test_max_msg();
    test_disconnect_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
